// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents: transmitter FSM state type, default baud divider and default
// register address, and a saturating counter helper.
package uart_pkg;

    // Transmitter frame sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock / 115200 baud.
    localparam int unsigned CLK_DIV_DEFAULT = 434;

    // Byte address of the transmit data register.
    localparam logic [31:0] TX_ADDR_DEFAULT = 32'hFFFF_FF00;

    // Increment an 8-bit counter, holding at its maximum value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor store bus as seen by the UART transmitter.
// Signals: MemWrite (store strobe), DataAdr (byte address), WriteData (store data).
// Modports: master drives the bus (processor / testbench), slave observes it (UART).
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;

    modport master (
        output MemWrite,
        output DataAdr,
        output WriteData
    );

    modport slave (
        input MemWrite,
        input DataAdr,
        input WriteData
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Ports:
//   clk, reset   : system clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  : write request and data; ignored when full
//   pop          : consume the head entry; ignored when empty
//   data         : current head entry (valid while empty=0)
//   full, empty  : derived from the registered occupancy count
//   count        : number of entries held, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        push_ok_s = push && (count_r != CW'(DEPTH));
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks net occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign data  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) with a transmit FIFO.
// A processor store to TX_ADDR queues WriteData[7:0]; the FSM drains the
// FIFO one frame at a time: start bit, 8 data bits LSB first, stop bit,
// each CLK_DIV cycles long. Stores arriving while the FIFO is full are
// dropped and counted.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   bus           : processor store bus (slave modport)
//   tx            : serial line, idle high, registered
//   busy          : frame in progress or bytes still queued
//   fifo_full     : FIFO holds DEPTH entries
//   overflow_cnt  : saturating count of dropped stores
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned DEPTH   = 8,
    parameter logic [31:0] TX_ADDR = TX_ADDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 fifo_full,
    output logic [7:0]           overflow_cnt
);
    localparam int unsigned CW       = $clog2(DEPTH) + 1;
    localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

    uart_state_e    state_r;
    logic           tx_r;
    logic [15:0]    baud_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic [7:0]     ovf_r;

    logic           hit_s;
    logic           push_s;
    logic           drop_s;
    logic           pop_s;
    logic           bit_end_s;
    logic [7:0]     head_s;
    logic           full_s;
    logic           empty_s;
    logic [CW-1:0]  count_s;
    logic           unused_wdata_s;

    // Only the low byte of a store is transmitted.
    assign unused_wdata_s = ^bus.WriteData[31:8];

    // Decode stores to the data register; full is the registered count,
    // so a store colliding with a pop on a full FIFO is still dropped.
    always_comb begin
        hit_s     = bus.MemWrite && (bus.DataAdr == TX_ADDR);
        push_s    = 1'b0;
        drop_s    = 1'b0;
        pop_s     = 1'b0;
        bit_end_s = (baud_r == BAUD_MAX);
        if (reset) begin
            push_s = 1'b0;
            drop_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            if (hit_s) begin
                if (full_s) begin
                    drop_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
                drop_s = 1'b0;
            end
            pop_s = (state_r == ST_IDLE) && !empty_s;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (bus.WriteData[7:0]),
        .pop   (pop_s),
        .data  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Dropped-store counter, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 8'd0;
        end else if (drop_s) begin
            ovf_r <= sat_inc8(ovf_r);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Frame sequencer: the baud counter restarts at every bit boundary and
    // state change, and IDLE always occupies at least one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            tx_r      <= 1'b1;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_r    <= 16'd0;
                    bit_idx_r <= 3'd0;
                    if (!empty_s) begin
                        shift_r <= head_s;
                        tx_r    <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        tx_r    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        baud_r    <= 16'd0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        baud_r    <= baud_r + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_r <= baud_r + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        baud_r  <= 16'd0;
                        tx_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        baud_r  <= baud_r + 16'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tx_r      <= 1'b1;
                    baud_r    <= 16'd0;
                    bit_idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign tx           = tx_r;
    assign busy         = (state_r != ST_IDLE) || (count_s != {CW{1'b0}});
    assign fifo_full    = full_s;
    assign overflow_cnt = ovf_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLK_DIV=4, DEPTH=8.
module tb_mmio_uart_tx;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DEPTH   = 8;
    localparam logic [31:0] TX_ADDR = 32'hFFFF_FF00;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        hit;
        logic [7:0]  exp_byte;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [7:0] overflow_cnt;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    vec_t vecs[10];

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .TX_ADDR (TX_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .tx           (tx),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One store presented for exactly one edge (E0); returns at E0+1.
    task automatic put(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        bus.MemWrite  = we;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        cyc(1);
        bus.MemWrite  = 1'b0;
    endtask

    // Called just after E0; checks a full frame carrying b and busy release.
    task automatic check_frame(input logic [7:0] b, input int id);
        check($sformatf("v%0d_pre_tx", id), tx, 1'b1);
        cyc(1);
        check($sformatf("v%0d_start_edge", id), tx, 1'b0);
        cyc(2);
        check($sformatf("v%0d_start_mid", id), tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(4);
            check($sformatf("v%0d_bit%0d", id, i), tx, b[i]);
        end
        cyc(4);
        check($sformatf("v%0d_stop", id), tx, 1'b1);
        cyc(1);
        check($sformatf("v%0d_busy_e40", id), busy, 1'b1);
        cyc(1);
        check($sformatf("v%0d_busy_e41", id), busy, 1'b0);
    endtask

    task automatic check_idle(input int n, input string name);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            cyc(1);
        end
        check(name, bad, 1'b0);
    endtask

    task automatic wait_idle(input int max, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            cyc(1);
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    // Line decoder: start detected on first low sample, mid-bit sampling.
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && tx === 1'b0) begin
                repeat (2) @(posedge clk);
                #1;
                check("mon_start", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1;
                    b[i] = tx;
                end
                repeat (4) @(posedge clk);
                #1;
                check("mon_stop", tx, 1'b1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed;
        int kind;
        logic [7:0] rb;

        vecs[0] = '{1'b1, TX_ADDR,         32'h0000_0055, 1'b1, 8'h55};
        vecs[1] = '{1'b1, 32'h0000_0064,   32'h0000_0007, 1'b0, 8'h00};
        vecs[2] = '{1'b1, TX_ADDR,         32'hABCD_1234, 1'b1, 8'h34};
        vecs[3] = '{1'b0, TX_ADDR,         32'h0000_0099, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 32'hFFFF_FF04,   32'h0000_0042, 1'b0, 8'h00};
        vecs[5] = '{1'b1, TX_ADDR,         32'h0000_0080, 1'b1, 8'h80};
        vecs[6] = '{1'b1, TX_ADDR,         32'hFFFF_FF01, 1'b1, 8'h01};
        vecs[7] = '{1'b1, TX_ADDR,         32'h0000_00FF, 1'b1, 8'hFF};
        vecs[8] = '{1'b1, TX_ADDR,         32'h0000_0000, 1'b1, 8'h00};
        vecs[9] = '{1'b1, 32'hFFFF_FE00,   32'h0000_00AA, 1'b0, 8'h00};

        // Reset with a simultaneous write hit, which must be ignored.
        reset         = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = TX_ADDR;
        bus.WriteData = 32'h0000_005A;
        cyc(3);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_ovf", overflow_cnt, 8'd0);
        reset        = 1'b0;
        bus.MemWrite = 1'b0;
        check_idle(20, "rst_write_ignored");

        // Table-driven single stores.
        for (int i = 0; i < 10; i++) begin
            put(vecs[i].we, vecs[i].adr, vecs[i].wdata);
            if (vecs[i].hit) begin
                check_frame(vecs[i].exp_byte, i);
            end else begin
                check_idle(45, $sformatf("v%0d_no_effect", i));
            end
        end

        // Ten consecutive hits: byte 0 pops at E1, so the 9th write fills the FIFO.
        rx_q.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            put(1'b1, TX_ADDR, 32'(k));
            if (k == 7) check("burst_not_full_after8", fifo_full, 1'b0);
            if (k == 8) check("burst_full_after9", fifo_full, 1'b1);
        end
        check("burst_ovf", overflow_cnt, 8'd1);
        wait_idle(600, "burst_drain");
        check("burst_rx_count", 32'(rx_q.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            rb = (k < rx_q.size()) ? rx_q[k] : 8'hXX;
            check($sformatf("burst_byte%0d", k), rb, 8'(k));
        end

        // Long run of hits drives the overflow counter into saturation.
        for (int k = 0; k < 300; k++) begin
            bus.MemWrite  = 1'b1;
            bus.DataAdr   = TX_ADDR;
            bus.WriteData = 32'(k);
            cyc(1);
        end
        bus.MemWrite = 1'b0;
        check("ovf_saturated", overflow_cnt, 8'd255);
        wait_idle(1500, "sat_drain");
        cyc(2);

        // Reset during DATA with three bytes queued, plus a hit in the reset cycle.
        mon_en = 1'b0;
        put(1'b1, TX_ADDR, 32'h11);
        put(1'b1, TX_ADDR, 32'h22);
        put(1'b1, TX_ADDR, 32'h33);
        put(1'b1, TX_ADDR, 32'h44);
        cyc(6);
        check("pre_reset_busy", busy, 1'b1);
        reset         = 1'b1;
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = TX_ADDR;
        bus.WriteData = 32'h0000_0077;
        cyc(1);
        reset        = 1'b0;
        bus.MemWrite = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_full", fifo_full, 1'b0);
        check("midrst_ovf", overflow_cnt, 8'd0);
        check_idle(100, "midrst_no_frames");

        // Random hits and misses against a scoreboard of accepted bytes.
        rx_q.delete();
        exp_q.delete();
        pushed = 0;
        mon_en = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 3));
            if (kind < 2 && (pushed - int'(rx_q.size())) < int'(DEPTH)) begin
                rb = 8'($urandom_range(0, 255));
                put(1'b1, TX_ADDR, {24'($urandom), rb});
                exp_q.push_back(rb);
                pushed++;
            end else if (kind == 2) begin
                put(1'b1, TX_ADDR ^ (32'h1 << $urandom_range(0, 31)), 32'($urandom));
            end else begin
                put(1'b0, TX_ADDR, 32'($urandom));
            end
            cyc(int'($urandom_range(1, 20)));
        end
        wait_idle(DEPTH * 45 + 100, "rand_drain");
        check("rand_rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            rb = (k < rx_q.size()) ? rx_q[k] : 8'hXX;
            check($sformatf("rand_byte%0d", k), rb, exp_q[k]);
        end
        check("rand_ovf", overflow_cnt, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
